// File: rtl/cpu_sequencer.sv
// cpu_sequencer: host-side issuer for the cpu block's load/in/s/w handshake.
// Instructions are queued in a small circular FIFO and drained one at a time
// into the CPU while run is high. Each instruction's result and flags are
// captured when the CPU returns to its wait state.
module cpu_sequencer #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        run,
  output logic        full,
  output logic        empty,
  output logic        overflow,
  output logic        busy,
  output logic        error,
  output logic        cpu_load,
  output logic [15:0] cpu_in,
  output logic        cpu_s,
  input  logic        cpu_w,
  input  logic [15:0] cpu_out,
  input  logic        cpu_N,
  input  logic        cpu_V,
  input  logic        cpu_Z,
  output logic [15:0] result,
  output logic [2:0]  flags,
  output logic        result_valid,
  output logic [7:0]  retired
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [15:0]      cpu_in_q, cpu_in_d;
  logic [15:0]      result_q, result_d;
  logic [2:0]       flags_q, flags_d;
  logic             result_valid_q, result_valid_d;
  logic [7:0]       retired_q, retired_d;
  logic             overflow_q, overflow_d;
  logic             error_q, error_d;

  logic [15:0]      mem [DEPTH];
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // FIFO storage write port.
  // NOTE: the storage array has no reset; a word is only ever read after the
  // reset-cleared count says it was written, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= wr_data;
  end

  // Next-state logic for the FIFO bookkeeping, sequencer FSM, watchdog and
  // captured results.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement can leave one unassigned and infer a latch.
    state_d        = state_q;
    wd_d           = wd_q;
    cpu_in_d       = cpu_in_q;
    result_d       = result_q;
    flags_d        = flags_q;
    result_valid_d = 1'b0;
    retired_d      = retired_q;
    error_d        = error_q;

    // A push while full is dropped even if a pop frees a slot this cycle.
    push       = wr_en && !fifo_full;
    pop        = (state_q == S_LOAD);
    overflow_d = overflow_q | (wr_en && fifo_full);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (run && !fifo_empty && cpu_w) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_START;
        wd_d    = '0;
      end
      S_START: begin
        if (!cpu_w) begin
          state_d = S_EXEC;
          wd_d    = '0;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_EXEC: begin
        if (cpu_w) begin
          state_d = S_CAPTURE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          state_d = S_ERROR;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_CAPTURE: begin
        result_d       = cpu_out;
        flags_d        = {cpu_N, cpu_V, cpu_Z};
        result_valid_d = 1'b1;
        retired_d      = retired_q + 8'd1;
        state_d        = (run && !fifo_empty) ? S_LOAD : S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERROR) error_d = 1'b1;
    // Present the FIFO head during LOAD and hold it afterwards so the CPU's
    // instruction register always sees a stable word.
    if (state_d == S_LOAD) cpu_in_d = mem[rd_ptr_q];
  end

  // State registers, cleared asynchronously.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      wd_q           <= '0;
      cpu_in_q       <= '0;
      result_q       <= '0;
      flags_q        <= '0;
      result_valid_q <= 1'b0;
      retired_q      <= '0;
      overflow_q     <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      wd_q           <= wd_d;
      cpu_in_q       <= cpu_in_d;
      result_q       <= result_d;
      flags_q        <= flags_d;
      result_valid_q <= result_valid_d;
      retired_q      <= retired_d;
      overflow_q     <= overflow_d;
      error_q        <= error_d;
    end
  end

  assign full         = fifo_full;
  assign empty        = fifo_empty;
  assign overflow     = overflow_q;
  assign error        = error_q;
  assign busy         = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign cpu_load     = (state_q == S_LOAD);
  assign cpu_s        = (state_q == S_START);
  assign cpu_in       = cpu_in_q;
  assign result       = result_q;
  assign flags        = flags_q;
  assign result_valid = result_valid_q;
  assign retired      = retired_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed, table-driven and randomized checks of
// cpu_sequencer against a reactive CPU model and a queue-based scoreboard.
module tb_cpu_sequencer;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        run;
  logic        full, empty, overflow, busy, error;
  logic        cpu_load, cpu_s, cpu_w;
  logic [15:0] cpu_in, cpu_out;
  logic [2:0]  cpu_nvz;
  logic [15:0] result;
  logic [2:0]  flags;
  logic        result_valid;
  logic [7:0]  retired;

  // CPU model controls
  int          cpu_k;
  logic        cpu_hang;
  logic [15:0] ir;
  logic        m_busy;
  int          m_cnt;

  int total;
  int bad;

  // scoreboard state
  logic [15:0] sb_q[$];
  logic [15:0] sb_infl[$];
  int          sb_ret;
  logic        sb_ovf;

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_data;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_ovf;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  cpu_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(rst_n),
    .wr_en(wr_en), .wr_data(wr_data), .run(run),
    .full(full), .empty(empty), .overflow(overflow), .busy(busy), .error(error),
    .cpu_load(cpu_load), .cpu_in(cpu_in), .cpu_s(cpu_s), .cpu_w(cpu_w),
    .cpu_out(cpu_out), .cpu_N(cpu_nvz[2]), .cpu_V(cpu_nvz[1]), .cpu_Z(cpu_nvz[0]),
    .result(result), .flags(flags), .result_valid(result_valid), .retired(retired)
  );

  // What the modelled CPU computes for an instruction: {N,V,Z,out}.
  function automatic logic [18:0] cpu_fn(input logic [15:0] word);
    logic [15:0] o;
    o = {8'h00, word[7:0]};
    return {o[7], word[11], (o == 16'h0000), o};
  endfunction

  // Reactive CPU: drops w one cycle after seeing s, raises it after cpu_k
  // low cycles with the result; never drops w when cpu_hang is set.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_w   <= 1'b1;
      m_busy  <= 1'b0;
      m_cnt   <= 0;
      ir      <= '0;
      cpu_out <= '0;
      cpu_nvz <= '0;
    end else begin
      if (cpu_load) ir <= cpu_in;
      if (!m_busy) begin
        if (cpu_s && !cpu_hang) begin
          cpu_w  <= 1'b0;
          m_busy <= 1'b1;
          m_cnt  <= 1;
        end
      end else if (m_cnt >= cpu_k) begin
        cpu_w              <= 1'b1;
        m_busy             <= 1'b0;
        {cpu_nvz, cpu_out} <= cpu_fn(ir);
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic sig_val(input int sel);
    case (sel)
      0:       return cpu_load;
      1:       return cpu_s;
      2:       return result_valid;
      3:       return error;
      4:       return busy;
      default: return 1'b0;
    endcase
  endfunction

  // Wait (bounded) at negedges until the selected signal equals val.
  task automatic wait_sig(input string name, input int sel, input logic val, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      got = (sig_val(sel) === val);
    end
    check({name, " wait"}, {31'd0, got}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    wr_data  = '0;
    run      = 1'b0;
    cpu_hang = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " cpu_load"},     cpu_load,     0);
    check({tag, " cpu_s"},        cpu_s,        0);
    check({tag, " cpu_in"},       cpu_in,       0);
    check({tag, " result"},       result,       0);
    check({tag, " flags"},        flags,        0);
    check({tag, " result_valid"}, result_valid, 0);
    check({tag, " retired"},      retired,      0);
    check({tag, " overflow"},     overflow,     0);
    check({tag, " error"},        error,        0);
    check({tag, " busy"},         busy,         0);
    check({tag, " full"},         full,         0);
    check({tag, " empty"},        empty,        1);
  endtask

  // One scoreboard cycle: compare the current cycle, then drive the next
  // inputs and advance the model FIFO by this cycle's pop and push.
  task automatic sb_step(input logic nxt_wr, input logic [15:0] nxt_data, input logic nxt_run);
    logic        full_now;
    logic [18:0] e;
    @(negedge clk);
    full_now = (sb_q.size() == DEPTH);
    check("rnd full",     full,     full_now);
    check("rnd empty",    empty,    sb_q.size() == 0);
    check("rnd overflow", overflow, sb_ovf);
    if (cpu_load) begin
      check("rnd load nonempty", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        check("rnd cpu_in", cpu_in, sb_q[0]);
        sb_infl.push_back(sb_q.pop_front());
      end
    end
    if (result_valid) begin
      sb_ret++;
      check("rnd rv inflight", sb_infl.size() != 0, 1);
      if (sb_infl.size() != 0) begin
        e = cpu_fn(sb_infl.pop_front());
        check("rnd result", result, e[15:0]);
        check("rnd flags",  flags,  e[18:16]);
      end
      check("rnd retired", retired, sb_ret % 256);
    end
    wr_en   = nxt_wr;
    wr_data = nxt_data;
    run     = nxt_run;
    if (nxt_wr) begin
      if (full_now) sb_ovf = 1'b1;
      else          sb_q.push_back(nxt_data);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] words[3];
    logic [15:0] loads[$];
    logic [18:0] e;
    int          rv;
    int          nl;
    int          extra;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    cpu_k = 3;
    do_reset();
    check_reset_vals("por");

    // ---- single instruction, issue latency ----
    wr_en = 1'b1; wr_data = 16'hD105; run = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    check("t1 no load in idle", cpu_load, 0);
    @(negedge clk);
    check("t1 load", cpu_load, 1);
    check("t1 cpu_in", cpu_in, 16'hD105);
    check("t1 busy", busy, 1);
    @(negedge clk);
    check("t1 load one cycle", cpu_load, 0);
    check("t1 start s", cpu_s, 1);
    check("t1 cpu_in held", cpu_in, 16'hD105);
    wait_sig("t1 s fall", 1, 1'b0, 20);
    check("t1 s held until w low", cpu_w, 0);
    wait_sig("t1 result_valid", 2, 1'b1, 20);
    check("t1 result", result, 16'h0005);
    check("t1 flags", flags, 3'b000);
    check("t1 retired", retired, 1);
    @(negedge clk);
    check("t1 rv pulse", result_valid, 0);
    check("t1 idle busy", busy, 0);
    check("t1 empty", empty, 1);
    run = 1'b0;

    // ---- back-to-back ----
    do_reset();
    words[0] = 16'h1A11; words[1] = 16'h2B82; words[2] = 16'h3C00;
    for (int i = 0; i < 3; i++) push(words[i]);
    check("b2b not empty", empty, 0);
    run = 1'b1;
    rv = 0;
    loads.delete();
    for (int c = 0; c < 200 && rv < 3; c++) begin
      @(negedge clk);
      if (cpu_load) loads.push_back(cpu_in);
      if (result_valid) begin
        e = cpu_fn(words[rv]);
        check($sformatf("b2b result%0d", rv), result, e[15:0]);
        if (rv < 2) check($sformatf("b2b no idle %0d", rv), cpu_load, 1);
        rv++;
      end
    end
    check("b2b loads", loads.size(), 3);
    for (int i = 0; i < 3 && i < loads.size(); i++)
      check($sformatf("b2b order%0d", i), loads[i], words[i]);
    @(negedge clk);
    check("b2b retired", retired, 3);
    check("b2b empty", empty, 1);
    check("b2b busy", busy, 0);
    run = 1'b0;

    // ---- full / overflow table ----
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 16'h1000 + 16'(i), (i == 7), 1'b0, 1'b0};
    vecs[8] = '{1'b1, 16'hBAD0, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_en   = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      @(negedge clk);
      check($sformatf("tbl%0d full", i),     full,     vecs[i].exp_full);
      check($sformatf("tbl%0d empty", i),    empty,    vecs[i].exp_empty);
      check($sformatf("tbl%0d overflow", i), overflow, vecs[i].exp_ovf);
    end
    wr_en = 1'b0;
    run   = 1'b1;
    nl    = 0;
    for (int c = 0; c < 400 && nl < 9; c++) begin
      @(negedge clk);
      if (cpu_load) begin
        check($sformatf("drain%0d", nl), cpu_in, 16'h1000 + nl);
        nl++;
      end
    end
    check("drain count", nl, 8);
    check("drain empty", empty, 1);
    check("drain retired", retired, 8);
    check("drain overflow sticky", overflow, 1);
    run = 1'b0;

    // ---- simultaneous push and pop ----
    do_reset();
    for (int i = 0; i < 7; i++) push(16'h4000 + 16'(i));
    check("pp 7 not full", full, 0);
    run = 1'b1;
    wait_sig("pp load", 0, 1'b1, 10);
    run = 1'b0; wr_en = 1'b1; wr_data = 16'h7777;
    @(negedge clk);
    wr_en = 1'b0;
    check("pp no overflow", overflow, 0);
    wait_sig("pp done", 4, 1'b0, 50);
    check("pp count below 8", full, 0);
    check("pp retired", retired, 1);
    push(16'h8888);
    check("pp count was 7", full, 1);

    // ---- run dropped mid-instruction ----
    do_reset();
    push(16'h2001);
    push(16'h2002);
    run = 1'b1;
    wait_sig("rd s rise", 1, 1'b1, 10);
    wait_sig("rd s fall", 1, 1'b0, 100);
    run = 1'b0;
    wait_sig("rd result_valid", 2, 1'b1, 50);
    e = cpu_fn(16'h2001);
    check("rd result", result, e[15:0]);
    check("rd retired", retired, 1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_load) extra++;
    end
    check("rd no further load", extra, 0);
    check("rd idle", busy, 0);
    check("rd one left", empty, 0);
    for (int i = 0; i < 6; i++) push(16'h5000 + 16'(i));
    check("rd 7 not full", full, 0);
    push(16'h5006);
    check("rd 8 full", full, 1);

    // ---- timeout ----
    do_reset();
    cpu_hang = 1'b1;
    push(16'h3003);
    run = 1'b1;
    wait_sig("to s rise", 1, 1'b1, 10);
    repeat (TIMEOUT - 4) @(negedge clk);
    check("to not early", error, 0);
    check("to still start", cpu_s, 1);
    wait_sig("to error", 3, 1'b1, 10);
    check("to cpu_s", cpu_s, 0);
    check("to busy", busy, 0);
    check("to cpu_load", cpu_load, 0);
    push(16'h3004);
    check("to push accepted", empty, 0);
    repeat (20) @(negedge clk);
    check("to error sticky", error, 1);
    check("to stays idle", busy, 0);
    check("to no s", cpu_s, 0);
    run = 1'b0;

    // ---- reset mid-EXEC ----
    do_reset();
    cpu_k = 6;
    push(16'h6001); push(16'h6002); push(16'h6003);
    run = 1'b1;
    wait_sig("rst first rv", 2, 1'b1, 100);
    check("rst retired 1", retired, 1);
    wait_sig("rst s rise", 1, 1'b1, 5);
    wait_sig("rst s fall", 1, 1'b0, 30);
    check("rst in exec", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid");
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // ---- randomized scoreboard ----
    do_reset();
    cpu_k = $urandom_range(1, 4);
    sb_q.delete();
    sb_infl.delete();
    sb_ret = 0;
    sb_ovf = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      logic w;
      w = (c < 700) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      sb_step(w, 16'($urandom), $urandom_range(0, 7) != 0);
    end
    for (int c = 0; c < 2000 && (sb_q.size() != 0 || sb_infl.size() != 0); c++)
      sb_step(1'b0, 16'h0000, 1'b1);
    check("rnd drained", sb_q.size() + sb_infl.size(), 0);
    check("rnd no error", error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
